// File: rtl/nw_pkg.sv
// nw_pkg: shared types, error-bit indices, defaults and helpers for the NW harness
package nw_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;
  localparam int ERR_SEQA = 0;
  localparam int ERR_SEQB = 1;
  localparam int ERR_ALNA = 2;
  localparam int ERR_ALNB = 3;
  localparam int ERR_LOAD = 4;
  localparam int ERR_TO = 5;
  localparam int DEF_DW = 8;
  localparam int DEF_SEQ_LEN = 128;
  localparam int DEF_ALN_LEN = 256;
  function automatic bit read_lat_ok(int lat);
    return lat >= 1 && lat <= 4;
  endfunction
  function automatic logic [31:0] sat_inc(logic [31:0] c);
    return &c ? c : c + 32'd1;
  endfunction
endpackage

// File: rtl/nw_rd_chan.sv
// nw_rd_chan: loadable sequence buffer with valid-tagged read latency pipeline and access counter
module nw_rd_chan import nw_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  parameter int SEQ_AW = 15,
  parameter int READ_LAT = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ld_we,
  input  logic [SEQ_AW-1:0] ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              ce,
  input  logic [SEQ_AW-1:0] addr,
  input  logic              cnt_clr,
  output logic [DW-1:0]     q,
  output logic              oob,
  output logic [31:0]       cnt
);
  localparam int IW = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1;
  logic [DW-1:0] mem [SEQ_LEN];
  logic [DW-1:0] sd [READ_LAT];
  logic [READ_LAT-1:0] sv;
  logic [DW-1:0] q_hold;
  logic in_rng, ld_rng;
  assign in_rng = 32'(addr) < SEQ_LEN;
  assign ld_rng = 32'(ld_addr) < SEQ_LEN;
  assign oob = ce && !in_rng;
  // q follows the tail stage only while it carries a tag, otherwise it repeats itself
  assign q = sv[READ_LAT-1] ? sd[READ_LAT-1] : q_hold;
  always_ff @(posedge ap_clk) begin
    if (ld_we && ld_rng) mem[ld_addr[IW-1:0]] <= ld_data;
    sd[0] <= in_rng ? mem[addr[IW-1:0]] : '0;
    for (int i = 1; i < READ_LAT; i++) sd[i] <= sd[i-1];
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sv <= '0;
      q_hold <= '0;
      cnt <= '0;
    end else begin
      sv <= (sv << 1) | READ_LAT'(ce);
      q_hold <= q;
      cnt <= cnt_clr ? '0 : ce ? sat_inc(cnt) : cnt;
    end
  end
endmodule

// File: rtl/nw_mem_harness.sv
// nw_mem_harness: memory and ap_ctrl_hs job sequencer for the Needleman-Wunsch kernel
module nw_mem_harness import nw_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  parameter int ALN_LEN = DEF_ALN_LEN,
  parameter int SEQ_AW = 15,
  parameter int ALN_AW = 16,
  parameter int READ_LAT = 1,
  parameter int TIMEOUT = 1000000
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              go,
  input  logic [31:0]       num_jobs,
  output logic              busy,
  output logic              done,
  output logic [31:0]       job_cnt,
  output logic [5:0]        err_flags,
  input  logic              ld_valid,
  input  logic              ld_sel,
  input  logic [SEQ_AW-1:0] ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              rb_sel,
  input  logic [ALN_AW-1:0] rb_addr,
  output logic [DW-1:0]     rb_data,
  output logic              dut_start,
  input  logic              dut_ready,
  input  logic              dut_done,
  input  logic              SEQA_ce0,
  input  logic              SEQB_ce0,
  input  logic [SEQ_AW-1:0] SEQA_address0,
  input  logic [SEQ_AW-1:0] SEQB_address0,
  output logic [DW-1:0]     SEQA_q0,
  output logic [DW-1:0]     SEQB_q0,
  input  logic              alignedA_ce0,
  input  logic              alignedA_we0,
  input  logic              alignedB_ce0,
  input  logic              alignedB_we0,
  input  logic [ALN_AW-1:0] alignedA_address0,
  input  logic [ALN_AW-1:0] alignedB_address0,
  input  logic [DW-1:0]     alignedA_d0,
  input  logic [DW-1:0]     alignedB_d0,
  output logic [31:0]       rd_cnt_a,
  output logic [31:0]       rd_cnt_b,
  output logic [31:0]       wr_cnt_a,
  output logic [31:0]       wr_cnt_b
);
  localparam int LAT = read_lat_ok(READ_LAT) ? READ_LAT : 1;
  localparam int AIW = ALN_LEN > 1 ? $clog2(ALN_LEN) : 1;
  state_t state, nxt;
  logic [31:0] jobs, wd;
  logic [5:0] err_new;
  logic [DW-1:0] aln_a [ALN_LEN];
  logic [DW-1:0] aln_b [ALN_LEN];
  logic idle, go_acc, fin, tmo, oob_a, oob_b, wa, wb, wa_ok, wb_ok, rb_ok;
  assign idle = state == S_IDLE || state == S_DONE;
  assign go_acc = go && idle;
  assign wa = alignedA_ce0 && alignedA_we0;
  assign wb = alignedB_ce0 && alignedB_we0;
  assign wa_ok = wa && 32'(alignedA_address0) < ALN_LEN;
  assign wb_ok = wb && 32'(alignedB_address0) < ALN_LEN;
  assign rb_ok = 32'(rb_addr) < ALN_LEN;
  nw_rd_chan #(.DW(DW), .SEQ_LEN(SEQ_LEN), .SEQ_AW(SEQ_AW), .READ_LAT(LAT)) u_seqa (
    .ap_clk, .ap_rst, .ld_we(ld_valid && idle && !ld_sel), .ld_addr, .ld_data,
    .ce(SEQA_ce0), .addr(SEQA_address0), .cnt_clr(go_acc), .q(SEQA_q0), .oob(oob_a), .cnt(rd_cnt_a)
  );
  nw_rd_chan #(.DW(DW), .SEQ_LEN(SEQ_LEN), .SEQ_AW(SEQ_AW), .READ_LAT(LAT)) u_seqb (
    .ap_clk, .ap_rst, .ld_we(ld_valid && idle && ld_sel), .ld_addr, .ld_data,
    .ce(SEQB_ce0), .addr(SEQB_address0), .cnt_clr(go_acc), .q(SEQB_q0), .oob(oob_b), .cnt(rd_cnt_b)
  );
  always_comb begin
    fin = (state == S_START && dut_ready && dut_done) || (state == S_RUN && dut_done);
    // a job finishing on the watchdog's last cycle counts as completed, not timed out
    tmo = !fin && (state == S_START || state == S_RUN) && wd == 32'(TIMEOUT - 1);
    nxt = go_acc ? (num_jobs == 32'd0 ? S_DONE : S_START) :
          fin ? (job_cnt + 32'd1 == jobs ? S_DONE : S_START) :
          tmo ? S_DONE :
          (state == S_START && dut_ready) ? S_RUN : state;
    err_new = '0;
    err_new[ERR_SEQA] = oob_a;
    err_new[ERR_SEQB] = oob_b;
    err_new[ERR_ALNA] = wa && !wa_ok;
    err_new[ERR_ALNB] = wb && !wb_ok;
    err_new[ERR_LOAD] = ld_valid && !idle;
    err_new[ERR_TO] = tmo;
  end
  always_ff @(posedge ap_clk) begin
    if (wa_ok) aln_a[alignedA_address0[AIW-1:0]] <= alignedA_d0;
    if (wb_ok) aln_b[alignedB_address0[AIW-1:0]] <= alignedB_d0;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      dut_start <= 1'b0;
      jobs <= '0;
      job_cnt <= '0;
      wd <= '0;
      err_flags <= '0;
      wr_cnt_a <= '0;
      wr_cnt_b <= '0;
      rb_data <= '0;
    end else begin
      state <= nxt;
      busy <= nxt == S_START || nxt == S_RUN;
      done <= nxt == S_DONE;
      dut_start <= nxt == S_START;
      jobs <= go_acc ? num_jobs : jobs;
      job_cnt <= go_acc ? '0 : fin ? job_cnt + 32'd1 : job_cnt;
      wd <= (nxt == S_START && (state != S_START || fin)) ? '0 : wd + 32'd1;
      err_flags <= go_acc ? '0 : err_flags | err_new;
      wr_cnt_a <= go_acc ? '0 : wa ? sat_inc(wr_cnt_a) : wr_cnt_a;
      wr_cnt_b <= go_acc ? '0 : wb ? sat_inc(wr_cnt_b) : wr_cnt_b;
      rb_data <= !rb_ok ? '0 : rb_sel ? aln_b[rb_addr[AIW-1:0]] : aln_a[rb_addr[AIW-1:0]];
    end
  end
endmodule

// File: tb/tb_nw_mem_harness.sv
// tb_nw_mem_harness: scoreboard bench for the NW harness at read latencies 3 and 1
module tb_nw_mem_harness;
  logic ap_clk = 0, ap_rst = 1, go = 0, ld_valid = 0, ld_sel = 0, rb_sel = 0, dut_ready = 0, dut_done = 0;
  logic [31:0] num_jobs = 0;
  logic [14:0] ld_addr = 0, SEQA_address0 = 0, SEQB_address0 = 0;
  logic [7:0] ld_data = 0, alignedA_d0 = 0, alignedB_d0 = 0;
  logic [15:0] rb_addr = 0, alignedA_address0 = 0, alignedB_address0 = 0;
  logic SEQA_ce0 = 0, SEQB_ce0 = 0, alignedA_ce0 = 0, alignedA_we0 = 0, alignedB_ce0 = 0, alignedB_we0 = 0;
  logic busy, done, dut_start, l1_busy, l1_done, l1_start;
  logic [31:0] job_cnt, rd_cnt_a, rd_cnt_b, wr_cnt_a, wr_cnt_b;
  logic [31:0] l1_job_cnt, l1_rca, l1_rcb, l1_wca, l1_wcb;
  logic [5:0] err_flags, l1_err;
  logic [7:0] rb_data, SEQA_q0, SEQB_q0, l1_rb, l1_qa, l1_qb;

  nw_mem_harness #(.READ_LAT(3), .TIMEOUT(50)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .go(go), .num_jobs(num_jobs), .busy(busy), .done(done),
    .job_cnt(job_cnt), .err_flags(err_flags), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data), .dut_start(dut_start),
    .dut_ready(dut_ready), .dut_done(dut_done), .SEQA_ce0(SEQA_ce0), .SEQB_ce0(SEQB_ce0),
    .SEQA_address0(SEQA_address0), .SEQB_address0(SEQB_address0), .SEQA_q0(SEQA_q0), .SEQB_q0(SEQB_q0),
    .alignedA_ce0(alignedA_ce0), .alignedA_we0(alignedA_we0), .alignedB_ce0(alignedB_ce0),
    .alignedB_we0(alignedB_we0), .alignedA_address0(alignedA_address0), .alignedB_address0(alignedB_address0),
    .alignedA_d0(alignedA_d0), .alignedB_d0(alignedB_d0), .rd_cnt_a(rd_cnt_a), .rd_cnt_b(rd_cnt_b),
    .wr_cnt_a(wr_cnt_a), .wr_cnt_b(wr_cnt_b)
  );
  nw_mem_harness #(.READ_LAT(1), .TIMEOUT(50)) u_l1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .go(go), .num_jobs(num_jobs), .busy(l1_busy), .done(l1_done),
    .job_cnt(l1_job_cnt), .err_flags(l1_err), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(l1_rb), .dut_start(l1_start),
    .dut_ready(dut_ready), .dut_done(dut_done), .SEQA_ce0(SEQA_ce0), .SEQB_ce0(SEQB_ce0),
    .SEQA_address0(SEQA_address0), .SEQB_address0(SEQB_address0), .SEQA_q0(l1_qa), .SEQB_q0(l1_qb),
    .alignedA_ce0(alignedA_ce0), .alignedA_we0(alignedA_we0), .alignedB_ce0(alignedB_ce0),
    .alignedB_we0(alignedB_we0), .alignedA_address0(alignedA_address0), .alignedB_address0(alignedB_address0),
    .alignedA_d0(alignedA_d0), .alignedB_d0(alignedB_d0), .rd_cnt_a(l1_rca), .rd_cnt_b(l1_rcb),
    .wr_cnt_a(l1_wca), .wr_cnt_b(l1_wcb)
  );

  typedef struct {int due; logic ch; logic [7:0] val;} exp_t;
  typedef struct {logic ce; logic ch; logic [14:0] a; logic [7:0] e;} op_t;
  exp_t sb3[$];
  exp_t sb1[$];
  op_t ops[$];
  logic [7:0] m3 [2];
  logic [7:0] m1 [2];
  int checks = 0, errors = 0, cyc = 0, starts = 0;
  logic prev_start = 0;

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;
  always @(negedge ap_clk) begin
    if (dut_start && !prev_start) starts <= starts + 1;
    prev_start <= dut_start;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wr_aln(input logic ch, input logic we, input logic [15:0] a, input logic [7:0] d);
    alignedA_ce0 = !ch; alignedA_we0 = !ch && we; alignedB_ce0 = ch; alignedB_we0 = ch && we;
    alignedA_address0 = a; alignedB_address0 = a; alignedA_d0 = d; alignedB_d0 = d;
    @(negedge ap_clk);
    alignedA_ce0 = 0; alignedA_we0 = 0; alignedB_ce0 = 0; alignedB_we0 = 0;
  endtask

  // drives queued read ops one per cycle; each q0 is compared every cycle to the latency model
  task automatic run_reads();
    int n = ops.size();
    exp_t e;
    for (int k = 0; k < n + 8; k++) begin
      SEQA_ce0 = 0; SEQB_ce0 = 0;
      if (k < n && ops[k].ce) begin
        SEQA_ce0 = !ops[k].ch; SEQB_ce0 = ops[k].ch;
        SEQA_address0 = ops[k].a; SEQB_address0 = ops[k].a;
        sb3.push_back('{cyc + 3, ops[k].ch, ops[k].e});
        sb1.push_back('{cyc + 1, ops[k].ch, ops[k].e});
      end
      @(negedge ap_clk);
      while (sb3.size() > 0 && sb3[0].due <= cyc) begin e = sb3.pop_front(); m3[e.ch] = e.val; end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin e = sb1.pop_front(); m1[e.ch] = e.val; end
      checks++; if (SEQA_q0 !== m3[0]) begin errors++; $display("FAIL lat3_seqa_q0 cyc %0d: got %h expected %h", cyc, SEQA_q0, m3[0]); end
      checks++; if (SEQB_q0 !== m3[1]) begin errors++; $display("FAIL lat3_seqb_q0 cyc %0d: got %h expected %h", cyc, SEQB_q0, m3[1]); end
      checks++; if (l1_qa !== m1[0]) begin errors++; $display("FAIL lat1_seqa_q0 cyc %0d: got %h expected %h", cyc, l1_qa, m1[0]); end
      checks++; if (l1_qb !== m1[1]) begin errors++; $display("FAIL lat1_seqb_q0 cyc %0d: got %h expected %h", cyc, l1_qb, m1[1]); end
    end
    ops.delete();
  endtask

  task automatic test_reset();
    ap_rst = 1;
    repeat (3) @(negedge ap_clk);
    checks++; if (busy !== 0 || done !== 0 || dut_start !== 0) begin errors++; $display("FAIL reset_ctrl: got %b%b%b expected 000", busy, done, dut_start); end
    checks++; if (err_flags !== 0 || job_cnt !== 0) begin errors++; $display("FAIL reset_err_job: got %h %h expected 0 0", err_flags, job_cnt); end
    checks++; if (rd_cnt_a !== 0 || rd_cnt_b !== 0 || wr_cnt_a !== 0 || wr_cnt_b !== 0) begin errors++; $display("FAIL reset_cnt: got nonzero counter"); end
    checks++; if (SEQA_q0 !== 0 || SEQB_q0 !== 0 || rb_data !== 0 || l1_qa !== 0) begin errors++; $display("FAIL reset_data: got %h %h %h expected 0", SEQA_q0, SEQB_q0, rb_data); end
    ap_rst = 0;
    m3 = '{8'h0, 8'h0}; m1 = '{8'h0, 8'h0};
    @(negedge ap_clk);
  endtask

  task automatic test_load();
    logic [7:0] sa [4] = '{8'h74, 8'h63, 8'h67, 8'h61};
    logic [7:0] sb [4] = '{8'h61, 8'h63, 8'h67, 8'h74};
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1; ld_sel = i >= 4; ld_addr = 15'(i % 4); ld_data = i < 4 ? sa[i] : sb[i-4];
      @(negedge ap_clk);
    end
    ld_sel = 0; ld_addr = 128; ld_data = 8'h55;
    @(negedge ap_clk);
    ld_valid = 0;
    @(negedge ap_clk);
    checks++; if (err_flags !== 0) begin errors++; $display("FAIL load_oob_noflag: got %b expected 000000", err_flags); end
  endtask

  task automatic test_read_single();
    ops.push_back('{1'b1, 1'b0, 15'd2, 8'h67});
    run_reads();
    checks++; if (rd_cnt_a !== 1 || l1_rca !== 1) begin errors++; $display("FAIL rd_cnt_single: got %0d %0d expected 1", rd_cnt_a, l1_rca); end
  endtask

  task automatic test_read_b2b();
    ops.push_back('{1'b1, 1'b0, 15'd0, 8'h74});
    ops.push_back('{1'b1, 1'b0, 15'd1, 8'h63});
    ops.push_back('{1'b1, 1'b0, 15'd2, 8'h67});
    ops.push_back('{1'b1, 1'b1, 15'd3, 8'h74});
    ops.push_back('{1'b0, 1'b0, 15'd0, 8'h00});
    ops.push_back('{1'b1, 1'b1, 15'd0, 8'h61});
    run_reads();
    checks++; if (rd_cnt_a !== 4 || rd_cnt_b !== 2) begin errors++; $display("FAIL rd_cnt_b2b: got %0d %0d expected 4 2", rd_cnt_a, rd_cnt_b); end
  endtask

  task automatic test_readback();
    wr_aln(0, 1, 5, 8'h5a);
    wr_aln(1, 1, 7, 8'hb7);
    wr_aln(0, 0, 9, 8'hee);
    checks++; if (wr_cnt_a !== 1 || wr_cnt_b !== 1) begin errors++; $display("FAIL wr_cnt: got %0d %0d expected 1 1", wr_cnt_a, wr_cnt_b); end
    rb_sel = 1; rb_addr = 7;
    @(negedge ap_clk);
    checks++; if (rb_data !== 8'hb7) begin errors++; $display("FAIL rb_b7: got %h expected b7", rb_data); end
    rb_sel = 0; rb_addr = 5;
    wr_aln(0, 1, 5, 8'h11);
    checks++; if (rb_data !== 8'h5a) begin errors++; $display("FAIL rb_read_first: got %h expected 5a", rb_data); end
    @(negedge ap_clk);
    checks++; if (rb_data !== 8'h11) begin errors++; $display("FAIL rb_after_write: got %h expected 11", rb_data); end
    rb_addr = 256;
    @(negedge ap_clk);
    checks++; if (rb_data !== 8'h00 || l1_rb !== 8'h00) begin errors++; $display("FAIL rb_oob: got %h expected 00", rb_data); end
  endtask

  task automatic test_oob();
    ops.push_back('{1'b1, 1'b0, 15'd200, 8'h00});
    ops.push_back('{1'b1, 1'b1, 15'd128, 8'h00});
    run_reads();
    checks++; if (err_flags !== 6'b000011) begin errors++; $display("FAIL err_seq_oob: got %b expected 000011", err_flags); end
    checks++; if (rd_cnt_a !== 5 || rd_cnt_b !== 3) begin errors++; $display("FAIL rd_cnt_oob: got %0d %0d expected 5 3", rd_cnt_a, rd_cnt_b); end
    wr_aln(1, 1, 44, 8'h44);
    wr_aln(1, 1, 300, 8'h99);
    checks++; if (err_flags !== 6'b001011 || wr_cnt_b !== 3) begin errors++; $display("FAIL alnb_oob: got %b %0d expected 001011 3", err_flags, wr_cnt_b); end
    wr_aln(0, 1, 256, 8'h77);
    checks++; if (err_flags !== 6'b001111) begin errors++; $display("FAIL alna_oob: got %b expected 001111", err_flags); end
    rb_sel = 1; rb_addr = 44;
    @(negedge ap_clk);
    checks++; if (rb_data !== 8'h44) begin errors++; $display("FAIL alnb_drop: got %h expected 44", rb_data); end
  endtask

  task automatic test_jobs();
    int base = starts;
    num_jobs = 3; go = 1;
    @(negedge ap_clk);
    go = 0;
    checks++; if (busy !== 1 || err_flags !== 0 || rd_cnt_a !== 0 || wr_cnt_b !== 0) begin errors++; $display("FAIL go_clear: got busy %b err %b rd %0d wr %0d expected 1 0 0 0", busy, err_flags, rd_cnt_a, wr_cnt_b); end
    for (int j = 0; j < 3; j++) begin
      for (int w = 0; w < 20 && !dut_start; w++) @(negedge ap_clk);
      checks++; if (dut_start !== 1) begin errors++; $display("FAIL job%0d_start: got %b expected 1", j, dut_start); end
      dut_ready = 1;
      @(negedge ap_clk);
      dut_ready = 0;
      checks++; if (dut_start !== 0 || busy !== 1) begin errors++; $display("FAIL job%0d_run: got start %b busy %b expected 0 1", j, dut_start, busy); end
      repeat (9) @(negedge ap_clk);
      dut_done = 1;
      @(negedge ap_clk);
      dut_done = 0;
    end
    checks++; if (done !== 1 || busy !== 0 || job_cnt !== 3 || l1_job_cnt !== 3) begin errors++; $display("FAIL jobs_done: got done %b busy %b cnt %0d expected 1 0 3", done, busy, job_cnt); end
    checks++; if (starts - base !== 3 || dut_start !== 0) begin errors++; $display("FAIL jobs_starts: got %0d expected 3", starts - base); end
    checks++; if (err_flags !== 0) begin errors++; $display("FAIL jobs_err: got %b expected 000000", err_flags); end
  endtask

  task automatic test_timeout();
    int s;
    num_jobs = 2; go = 1;
    @(negedge ap_clk);
    go = 0; s = cyc;
    ld_valid = 1; ld_sel = 0; ld_addr = 0; ld_data = 8'hff;
    @(negedge ap_clk);
    ld_valid = 0;
    while (cyc < s + 49) @(negedge ap_clk);
    checks++; if (busy !== 1 || dut_start !== 1 || err_flags !== 6'b010000) begin errors++; $display("FAIL pre_timeout: got busy %b start %b err %b expected 1 1 010000", busy, dut_start, err_flags); end
    @(negedge ap_clk);
    checks++; if (done !== 1 || busy !== 0 || dut_start !== 0) begin errors++; $display("FAIL timeout_state: got done %b busy %b start %b expected 1 0 0", done, busy, dut_start); end
    checks++; if (err_flags !== 6'b110000 || job_cnt !== 0) begin errors++; $display("FAIL timeout_err: got %b %0d expected 110000 0", err_flags, job_cnt); end
    ops.push_back('{1'b1, 1'b0, 15'd0, 8'h74});
    run_reads();
  endtask

  task automatic test_zero_jobs();
    int base = starts;
    num_jobs = 0; go = 1;
    @(negedge ap_clk);
    go = 0;
    checks++; if (done !== 1 || busy !== 0 || err_flags !== 0 || job_cnt !== 0) begin errors++; $display("FAIL zero_jobs: got done %b busy %b err %b expected 1 0 0", done, busy, err_flags); end
    repeat (3) @(negedge ap_clk);
    checks++; if (starts !== base || dut_start !== 0 || done !== 1) begin errors++; $display("FAIL zero_jobs_start: got %0d starts expected 0", starts - base); end
  endtask

  task automatic test_reset_mid();
    num_jobs = 1; go = 1;
    @(negedge ap_clk);
    go = 0; dut_ready = 1;
    @(negedge ap_clk);
    dut_ready = 0;
    checks++; if (busy !== 1 || dut_start !== 0) begin errors++; $display("FAIL mid_run: got busy %b start %b expected 1 0", busy, dut_start); end
    ap_rst = 1;
    @(negedge ap_clk);
    ap_rst = 0;
    checks++; if (busy !== 0 || dut_start !== 0 || done !== 0 || SEQA_q0 !== 0) begin errors++; $display("FAIL reset_run: got busy %b start %b done %b q %h expected 0 0 0 00", busy, dut_start, done, SEQA_q0); end
    go = 1;
    @(negedge ap_clk);
    go = 0;
    checks++; if (dut_start !== 1) begin errors++; $display("FAIL restart: got %b expected 1", dut_start); end
    ap_rst = 1;
    @(negedge ap_clk);
    ap_rst = 0;
    checks++; if (dut_start !== 0 || busy !== 0) begin errors++; $display("FAIL reset_start: got start %b busy %b expected 0 0", dut_start, busy); end
    SEQA_ce0 = 1; SEQA_address0 = 1;
    @(negedge ap_clk);
    SEQA_ce0 = 0; ap_rst = 1;
    @(negedge ap_clk);
    ap_rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      checks++; if (SEQA_q0 !== 0 || l1_qa !== 0) begin errors++; $display("FAIL flush%0d: got %h %h expected 00", k, SEQA_q0, l1_qa); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_read_single();
    test_read_b2b();
    test_readback();
    test_oob();
    test_jobs();
    test_timeout();
    test_zero_jobs();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nw_mem_harness.md
Name: nw_mem_harness

Overview:
- Synthesizable, parametrised memory and job-control harness for the Needleman-Wunsch HLS kernel (ap_ctrl_hs).
- Serves the two sequence read ports (SEQA/SEQB) from loadable internal buffers with configurable read latency.
- Captures the two aligned-output write ports into readable buffers.
- Sequences num_jobs start/done handshakes, with a watchdog, sticky error flags and per-channel access counters. Sits between the load/readback host logic and the kernel instance.

Parameters:
DW, 8, data width of all sequence/aligned entries
SEQ_LEN, 128, entries per sequence buffer
ALN_LEN, 256, entries per aligned buffer
SEQ_AW, 15, kernel SEQ address width
ALN_AW, 16, kernel aligned address width
READ_LAT, 1, ce-to-q latency in cycles (legal 1..4)
TIMEOUT, 1000000, max cycles per job before watchdog abort

Ports:
ap_clk  in  1  clock
ap_rst  in  1  reset; synchronous, active-high
go  in  1  pulse: latch num_jobs, clear flags/counters, start sequence
num_jobs  in  32  jobs to run
busy  out  1  job sequence in progress
done  out  1  sequence finished (held until next go)
job_cnt  out  32  jobs completed
err_flags  out  6  sticky: [0] SEQA oob, [1] SEQB oob, [2] alnA oob, [3] alnB oob, [4] load dropped, [5] timeout
ld_valid  in  1  load strobe
ld_sel  in  1  0=SEQA buffer, 1=SEQB buffer
ld_addr  in  SEQ_AW  load address
ld_data  in  DW  load data
rb_sel  in  1  0=alignedA, 1=alignedB
rb_addr  in  ALN_AW  readback address
rb_data  out  DW  readback data, 1-cycle latency
dut_start  out  1  to kernel ap_start
dut_ready, dut_done  in  1 each  from kernel
SEQA_ce0, SEQB_ce0  in  1 each  read enables
SEQA_address0, SEQB_address0  in  SEQ_AW each
SEQA_q0, SEQB_q0  out  DW each  read data
alignedA_ce0, alignedA_we0, alignedB_ce0, alignedB_we0  in  1 each
alignedA_address0, alignedB_address0  in  ALN_AW each
alignedA_d0, alignedB_d0  in  DW each
rd_cnt_a, rd_cnt_b, wr_cnt_a, wr_cnt_b  out  32 each  access counters

Behaviour:
- Reset: FSM IDLE; busy, done, dut_start, err_flags, job_cnt, counters, SEQ*_q0 and rb_data all 0. Buffer contents are not reset.
- FSM states: IDLE, START, RUN, DONE.
  - IDLE/DONE + go: latch num_jobs; clear job_cnt, err_flags and counters. If num_jobs==0, go to DONE next cycle; otherwise go to START.
  - START: dut_start=1. On dut_ready&dut_done in the same cycle, complete the job. On dut_ready alone, go to RUN.
  - RUN: dut_start=0. On dut_done, complete the job.
  - Job completion: job_cnt+1. If the new count equals the latched jobs, go to DONE; otherwise go to START next cycle.
  - go while in START/RUN is ignored.
- busy=1 in START/RUN. done=1 in DONE.
- Watchdog: counter reloads on entry to START and counts in START/RUN. On reaching TIMEOUT: set err[5], dut_start=0, go to DONE. job_cnt is not incremented.
- Loads: accepted only in IDLE/DONE. While busy, the load is dropped and err[4] is set. ld_addr>=SEQ_LEN is dropped with no flag.
- Read path (per channel):
  - ce0 at cycle t yields q0 valid from cycle t+READ_LAT via a valid-tagged shift pipeline.
  - q0 updates only when a tagged stage exits; otherwise it holds its last value.
  - Back-to-back ce is fully pipelined.
  - address>=SEQ_LEN returns 0 and sets err[0]/[1].
- Write path: ce0&we0 writes d0 at address0 on that edge. address>=ALN_LEN drops the write and sets err[2]/[3].
- Readback: rb_data = buffer[rb_sel][rb_addr] registered, 1 cycle later. Out-of-range returns 0. A same-cycle write to the same address returns the old data (read-first).
- Counters: increment on each read ce / write ce&we, including oob accesses. They saturate at 2^32-1 and clear on go.
- Error flags are sticky until go or reset.
- Mid-operation reset: the FSM aborts to IDLE, dut_start drops in the same cycle the reset is sampled, and the read pipelines flush.

Decomposition:
- nw_pkg holds:
  - FSM state enum
  - error-bit index constants
  - DW/SEQ_LEN/ALN_LEN defaults
  - a READ_LAT range-check function
- One sub-module, nw_rd_chan: buffer plus latency pipeline plus oob flag plus counter. Instantiated twice (SEQA, SEQB).

Test Plan:
- Load SEQA[0..3]="tcga", READ_LAT=1, ce at addr 2 in cycle t -> SEQA_q0=8'h67 ('g') at t+1; held while ce is low; rd_cnt_a=1.
- READ_LAT=3, ce back-to-back on addr 0,1,2 -> q0 = 't','c','g' on cycles t+3, t+4, t+5.
- num_jobs=3, kernel model asserts dut_ready one cycle after start and dut_done 10 cycles later -> three dut_start pulses, job_cnt=3, done=1, err_flags=0.
- Write alignedB addr 300 (ALN_LEN=256) -> write dropped, err[3]=1, wr_cnt_b=1. ld_valid while busy -> err[4]=1 and buffer unchanged.
- TIMEOUT=50, dut_done never asserted -> at cycle 50 after START: err[5]=1, state DONE, job_cnt=0, dut_start=0.
- num_jobs=0 with go -> done=1 next cycle and dut_start never asserted. Reset asserted mid-RUN -> busy=0, dut_start=0 on the next edge.
